// File: rtl/comp_operand_loader.sv
// Drives the nibble/push-button loading interface of an 8-bit comparator:
// presents four nibbles on Y, strobes PB1..PB4, then samples l/g/e once settled.
module comp_operand_loader #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       l,
   input  logic       g,
   input  logic       e,
   output logic [3:0] Y,
   output logic       PB1,
   output logic       PB2,
   output logic       PB3,
   output logic       PB4,
   output logic       busy,
   output logic       done,
   output logic       lt,
   output logic       gt,
   output logic       eq,
   output logic       err
);

   localparam int unsigned MAX_CYC = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESENT,
      S_STROBE,
      S_SETTLE,
      S_RELEASE
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       opa_q, opa_d;
   logic [7:0]       opb_q, opb_d;
   logic [3:0]       y_q, y_d;
   logic [3:0]       pb_q, pb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lt_q, lt_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;
   logic             err_q, err_d;
   logic [3:0]       nib;
   logic             one_hot;

   // Nibble selected by the current sequence index
   always_comb begin
      nib = 4'h0;
      case (idx_q)
         2'd0:    nib = opa_q[3:0];
         2'd1:    nib = opa_q[7:4];
         2'd2:    nib = opb_q[3:0];
         default: nib = opb_q[7:4];
      endcase
   end

   assign one_hot = ({l, g, e} == 3'b100) || ({l, g, e} == 3'b010) || ({l, g, e} == 3'b001);

   // Outputs follow the state one cycle later, so Y settles before each PB edge
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      y_d     = y_q;
      pb_d    = pb_q;
      busy_d  = busy_q;
      done_d  = done_q;
      lt_d    = lt_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            y_d    = 4'h0;
            pb_d   = 4'h0;
            busy_d = 1'b0;
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               busy_d  = 1'b1;
               idx_d   = 2'd0;
               cnt_d   = '0;
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            y_d = nib;
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               cnt_d   = '0;
               state_d = S_STROBE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STROBE: begin
            y_d   = nib;
            pb_d  = pb_q | (4'b0001 << idx_q);
            cnt_d = '0;
            if (idx_q == 2'd3) begin
               state_d = S_SETTLE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_PRESENT;
            end
         end
         S_SETTLE: begin
            y_d  = opb_q[7:4];
            pb_d = 4'hF;
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               lt_d    = l;
               gt_d    = g;
               eq_d    = e;
               err_d   = ~one_hot;
               done_d  = 1'b1;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            done_d  = 1'b0;
            pb_d    = 4'h0;
            y_d     = 4'h0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         opa_q   <= 8'h00;
         opb_q   <= 8'h00;
         y_q     <= 4'h0;
         pb_q    <= 4'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         y_q     <= y_d;
         pb_q    <= pb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         err_q   <= err_d;
      end
   end

   assign Y    = y_q;
   assign PB1  = pb_q[0];
   assign PB2  = pb_q[1];
   assign PB3  = pb_q[2];
   assign PB4  = pb_q[3];
   assign busy = busy_q;
   assign done = done_q;
   assign lt   = lt_q;
   assign gt   = gt_q;
   assign eq   = eq_q;
   assign err  = err_q;

endmodule

// File: tb/tb_comp_operand_loader.sv
// Bench for comp_operand_loader: two configurations, each driving a behavioural
// nibble-loaded comparator; timing and results predicted from cycle arithmetic.
module tb_comp_operand_loader;

   localparam int S1 = 1, SE1 = 2, S2 = 3, SE2 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start1, start2, force_lg;
   logic [7:0] a, b;
   int         checks = 0;
   int         errors = 0;
   int         sel = 0;
   logic [3:0] res_prev [2];

   logic [3:0] y1, y2, p1, p2;
   logic       l1, g1, e1, busy1, done1, lt1, gt1, eq1, err1;
   logic       l2, g2, e2, busy2, done2, lt2, gt2, eq2, err2;
   logic [3:0] mal1, mah1, mbl1, mbh1, mal2, mah2, mbl2, mbh2;

   comp_operand_loader #(.SETUP_CYC(S1), .SETTLE_CYC(SE1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
      .l(l1), .g(g1), .e(e1), .Y(y1),
      .PB1(p1[0]), .PB2(p1[1]), .PB3(p1[2]), .PB4(p1[3]),
      .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1), .err(err1));

   comp_operand_loader #(.SETUP_CYC(S2), .SETTLE_CYC(SE2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a), .b(b),
      .l(l2), .g(g2), .e(e2), .Y(y2),
      .PB1(p2[0]), .PB2(p2[1]), .PB3(p2[2]), .PB4(p2[3]),
      .busy(busy2), .done(done2), .lt(lt2), .gt(gt2), .eq(eq2), .err(err2));

   // Comparator models: load a nibble from Y on each PB rising edge
   always @(posedge p1[0]) mal1 = y1;
   always @(posedge p1[1]) mah1 = y1;
   always @(posedge p1[2]) mbl1 = y1;
   always @(posedge p1[3]) mbh1 = y1;
   always @(posedge p2[0]) mal2 = y2;
   always @(posedge p2[1]) mah2 = y2;
   always @(posedge p2[2]) mbl2 = y2;
   always @(posedge p2[3]) mbh2 = y2;

   assign l1 = force_lg ? 1'b1 : ({mah1, mal1} <  {mbh1, mbl1});
   assign g1 = force_lg ? 1'b1 : ({mah1, mal1} >  {mbh1, mbl1});
   assign e1 = force_lg ? 1'b0 : ({mah1, mal1} == {mbh1, mbl1});
   assign l2 = force_lg ? 1'b1 : ({mah2, mal2} <  {mbh2, mbl2});
   assign g2 = force_lg ? 1'b1 : ({mah2, mal2} >  {mbh2, mbl2});
   assign e2 = force_lg ? 1'b0 : ({mah2, mal2} == {mbh2, mbl2});

   wire [13:0] obs1 = {y1, p1, busy1, done1, lt1, gt1, eq1, err1};
   wire [13:0] obs2 = {y2, p2, busy2, done2, lt2, gt2, eq2, err2};

   function automatic logic [13:0] cur_obs();
      return (sel != 0) ? obs2 : obs1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start2 = v;
      else          start1 = v;
   endtask

   // One full compare from the selected DUT, checked every cycle after E0
   task automatic run(input logic [7:0] ta, input logic [7:0] tbv, input bit repulse);
      int s, se, n, p;
      logic [3:0]  nb [4];
      logic [3:0]  res_exp, pb_exp, y_exp;
      logic [13:0] o;
      s  = (sel != 0) ? S2 : S1;
      se = (sel != 0) ? SE2 : SE1;
      n  = 4 * (s + 1) + se;
      nb[0] = ta[3:0]; nb[1] = ta[7:4]; nb[2] = tbv[3:0]; nb[3] = tbv[7:4];
      if (force_lg) res_exp = 4'b1101;
      else          res_exp = {ta < tbv, ta > tbv, ta == tbv, 1'b0};
      a = ta; b = tbv;
      set_start(1'b1);
      for (int k = 0; k <= n + 3; k++) begin
         @(negedge clk);
         o = cur_obs();
         if (k == 0) y_exp = 4'h0;
         else if (k <= n) begin
            p = (k - 1) / (s + 1);
            if (p > 3) p = 3;
            y_exp = nb[p];
         end else y_exp = 4'h0;
         for (int i = 0; i < 4; i++) pb_exp[i] = (k >= (i + 1) * (s + 1)) && (k <= n);
         chk($sformatf("Y k=%0d", k), o[13:10], y_exp);
         chk($sformatf("PB k=%0d", k), o[9:6], pb_exp);
         chk($sformatf("busy k=%0d", k), o[5], k <= n);
         chk($sformatf("done k=%0d", k), o[4], k == n);
         chk($sformatf("result k=%0d", k), o[3:0], (k >= n) ? res_exp : res_prev[sel]);
         if (k == 0) set_start(1'b0);
         if (k == 1) begin a = 8'($urandom); b = 8'($urandom); end
         if (repulse && k == 2) set_start(1'b1);
         if (repulse && k == 3) set_start(1'b0);
      end
      res_prev[sel] = res_exp;
   endtask

   initial begin
      int done_at [$];
      int j;
      logic [7:0] ra, rb;
      rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; force_lg = 1'b0;
      a = 8'h00; b = 8'h00;
      res_prev[0] = 4'h0; res_prev[1] = 4'h0;
      repeat (3) @(negedge clk);
      chk("reset dut1", 32'(obs1), 32'h0);
      chk("reset dut2", 32'(obs2), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      sel = 0;
      run(8'h00, 8'h00, 1'b0);
      run(8'h08, 8'h01, 1'b0);
      run(8'h5A, 8'hA5, 1'b0);
      force_lg = 1'b1;
      run(8'($urandom), 8'($urandom), 1'b0);
      force_lg = 1'b0;
      run(8'h33, 8'h33, 1'b0);
      run(8'($urandom), 8'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         rb = (i % 3 == 0) ? ra : 8'($urandom);
         run(ra, rb, 1'b0);
      end

      // start held high: back-to-back sequences with one IDLE cycle between
      a = 8'h21; b = 8'h9C;
      start1 = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done1) done_at.push_back(k);
      end
      start1 = 1'b0;
      j = 0;
      while (busy1 && j < 40) begin @(negedge clk); j++; end
      chk("held drain busy", 32'(busy1), 32'h0);
      chk("held done count", 32'(done_at.size()), 32'd2);
      if (done_at.size() >= 2) begin
         chk("held done0", 32'(done_at[0]), 32'd10);
         chk("held done1", 32'(done_at[1]), 32'd22);
      end
      chk("held result", 32'({lt1, gt1, eq1, err1}), 32'b1000);
      res_prev[0] = 4'b1000;

      // Reset mid-sequence at E0+5 aborts with no result
      a = 8'hF0; b = 8'h0F;
      start1 = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         if (k == 0) start1 = 1'b0;
         if (k == 5) begin
            chk("midreset obs", 32'(obs1), 32'h0);
            rst_n = 1'b1;
         end
         if (k > 5) chk($sformatf("midreset done k=%0d", k), 32'(done1), 32'h0);
         if (k > 5) chk($sformatf("midreset busy k=%0d", k), 32'(busy1), 32'h0);
         if (k == 4) rst_n = 1'b0;
      end
      res_prev[0] = 4'h0;
      run(8'h7F, 8'h80, 1'b0);

      sel = 1;
      run(8'h5A, 8'hA5, 1'b0);
      run(8'($urandom), 8'($urandom), 1'b0);
      run(8'h44, 8'h44, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
